// File: rtl/probe_capture_ctrl_pkg.sv
// Shared types and defaults for the probe capture sequencer.
//   time_t / filt_t   : sample timestamp and signed filter-output formats
//   capture_entry_t   : one buffered {timestamp, value} pair
//   ST_*              : capture FSM state encodings
package probe_capture_ctrl_pkg;

  localparam int TIME_W = 32;
  localparam int FILT_W = 16;

  typedef logic [TIME_W-1:0]        time_t;
  typedef logic signed [FILT_W-1:0] filt_t;

  typedef struct packed {
    time_t tstamp;
    filt_t value;
  } capture_entry_t;

  localparam int CAPTURE_DEPTH    = 256;
  localparam int CAPTURE_PRE_TRIG = 64;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRETRIG   = 3'd1;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ST_POSTTRIG  = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

endpackage

// File: rtl/probe_capture_ctrl_if.sv
// Sample input stream and drain output stream of the probe capture block.
//   in_valid/in_time/in_value          : incoming filter samples
//   out_valid/out_ready/out_time/
//   out_value/out_last                 : valid/ready drain stream
// slave = capture block side, master = sample source / drain consumer side.
interface probe_capture_ctrl_if;
  import probe_capture_ctrl_pkg::*;

  logic  in_valid;
  time_t in_time;
  filt_t in_value;
  logic  out_valid;
  logic  out_ready;
  time_t out_time;
  filt_t out_value;
  logic  out_last;

  modport master (
    output in_valid, in_time, in_value, out_ready,
    input  out_valid, out_time, out_value, out_last
  );

  modport slave (
    input  in_valid, in_time, in_value, out_ready,
    output out_valid, out_time, out_value, out_last
  );

endinterface

// File: rtl/probe_capture_ctrl_ram.sv
// Capture buffer: simple dual-port RAM, one write port, one registered read port.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata valid the cycle after re
module probe_capture_ctrl_ram
  import probe_capture_ctrl_pkg::*;
#(
  parameter int DEPTH  = CAPTURE_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  capture_entry_t    wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output capture_entry_t    rdata
);

  capture_entry_t mem [DEPTH];

  // No reset on the array or read register so the tools can map this to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/probe_capture_ctrl.sv
// Probe capture sequencer: records decimated samples into a ring buffer, keeps
// PRE_TRIG samples of history, fires on a threshold crossing or forced trigger,
// completes the post-trigger window and drains DEPTH entries oldest first.
//   clk, rst            : clock, synchronous active-high reset
//   arm                 : start pulse (IDLE only)
//   force_trig          : unconditional trigger level (WAIT_TRIG only)
//   trig_rising         : 1 rising / 0 falling crossing
//   trig_level          : signed threshold
//   decim               : keep 1 of decim+1 valid samples, latched at arm
//   bus (slave)         : sample input stream and drain output stream
//   busy, triggered     : status
//
// state      | meaning
// IDLE       | waiting for arm, no writes
// PRETRIG    | filling PRE_TRIG history samples, trigger not evaluated
// WAIT_TRIG  | ring-writing, evaluating trigger on each accepted sample
// POSTTRIG   | writing the remaining post-trigger samples
// DRAIN      | reading DEPTH entries out through the 2-entry skid
module probe_capture_ctrl
  import probe_capture_ctrl_pkg::*;
#(
  parameter int DEPTH    = CAPTURE_DEPTH,
  parameter int PRE_TRIG = CAPTURE_PRE_TRIG,
  parameter int DECIM_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                force_trig,
  input  logic                trig_rising,
  input  filt_t               trig_level,
  input  logic [DECIM_W-1:0]  decim,
  probe_capture_ctrl_if.slave bus,
  output logic                busy,
  output logic                triggered
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int POST   = DEPTH - PRE_TRIG - 1;

  logic [2:0]         state;
  logic [ADDR_W-1:0]  wr_ptr, rd_ptr, trig_ptr, fill_cnt, post_cnt;
  logic [ADDR_W:0]    rd_cnt;
  logic [DECIM_W-1:0] decim_q, decim_cnt;
  filt_t              prev_value;
  logic               prev_valid;

  capture_entry_t     sk_mem [2];
  logic [1:0]         sk_last;
  logic               sk_head;
  logic [1:0]         sk_cnt;
  logic               sk_tail;
  logic               rd_inflight, rd_inflight_last;

  logic               capturing, accept, rise_hit, fall_hit, fire, pop, rd_issue;
  logic [2:0]         occ_next;
  capture_entry_t     wdata, rdata;

  assign capturing = (state == ST_PRETRIG) || (state == ST_WAIT_TRIG) || (state == ST_POSTTRIG);
  assign accept    = capturing && bus.in_valid && (decim_cnt == '0);
  assign rise_hit  = prev_valid && (prev_value < trig_level) && (bus.in_value >= trig_level);
  assign fall_hit  = prev_valid && (prev_value > trig_level) && (bus.in_value <= trig_level);
  assign fire      = (state == ST_WAIT_TRIG) && accept &&
                     (force_trig || (trig_rising ? rise_hit : fall_hit));
  assign wdata     = {bus.in_time, bus.in_value};

  // Skid occupancy after this cycle's arrival and pop; a read is issued only if
  // its data (landing next cycle) is guaranteed a slot even with no pop.
  assign pop      = bus.out_valid && bus.out_ready;
  assign occ_next = {1'b0, sk_cnt} + {2'b0, rd_inflight} - {2'b0, pop};
  assign rd_issue = (state == ST_DRAIN) && (rd_cnt != '0) && (occ_next < 3'd2);
  assign sk_tail  = sk_head ^ sk_cnt[0];

  assign bus.out_valid = (sk_cnt != 2'd0);
  assign bus.out_time  = sk_mem[sk_head].tstamp;
  assign bus.out_value = sk_mem[sk_head].value;
  assign bus.out_last  = bus.out_valid && sk_last[sk_head];
  assign busy          = (state != ST_IDLE);

  probe_capture_ctrl_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trig_ptr   <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      decim_q    <= '0;
      decim_cnt  <= '0;
      prev_value <= '0;
      prev_valid <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      if (capturing && bus.in_valid)
        decim_cnt <= (decim_cnt == '0) ? decim_q : decim_cnt - DECIM_W'(1);
      if (accept) begin
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        prev_value <= bus.in_value;
        prev_valid <= 1'b1;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        rd_cnt <= rd_cnt - (ADDR_W+1)'(1);
      end
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state      <= ST_PRETRIG;
            decim_q    <= decim;
            decim_cnt  <= '0;
            fill_cnt   <= '0;
            prev_valid <= 1'b0;
          end
        end
        ST_PRETRIG: begin
          if (accept) begin
            if (fill_cnt == ADDR_W'(PRE_TRIG - 1)) state <= ST_WAIT_TRIG;
            else fill_cnt <= fill_cnt + ADDR_W'(1);
          end
        end
        ST_WAIT_TRIG: begin
          if (fire) begin
            trig_ptr  <= wr_ptr;
            triggered <= 1'b1;
            if (POST == 0) begin
              state  <= ST_DRAIN;
              rd_ptr <= wr_ptr - ADDR_W'(PRE_TRIG);
              rd_cnt <= (ADDR_W+1)'(DEPTH);
            end else begin
              state    <= ST_POSTTRIG;
              post_cnt <= ADDR_W'(POST);
            end
          end
        end
        ST_POSTTRIG: begin
          if (accept) begin
            post_cnt <= post_cnt - ADDR_W'(1);
            if (post_cnt == ADDR_W'(1)) begin
              state  <= ST_DRAIN;
              rd_ptr <= trig_ptr - ADDR_W'(PRE_TRIG);
              rd_cnt <= (ADDR_W+1)'(DEPTH);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && bus.out_last) begin
            state     <= ST_IDLE;
            triggered <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output skid: two-entry FIFO fed by the registered RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      sk_mem[0]        <= '0;
      sk_mem[1]        <= '0;
      sk_last          <= '0;
      sk_head          <= 1'b0;
      sk_cnt           <= 2'd0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
    end else begin
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_issue && (rd_cnt == (ADDR_W+1)'(1));
      if (rd_inflight) begin
        sk_mem[sk_tail]  <= rdata;
        sk_last[sk_tail] <= rd_inflight_last;
      end
      if (pop) sk_head <= ~sk_head;
      sk_cnt <= occ_next[1:0];
    end
  end

endmodule
